// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK.
// Lines are open-drain; ps2c_oe/ps2d_oe = 1 pulls the line low.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Reloj,
  input  logic       RST,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic       WR,
  input  logic [7:0] DIN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int CMAX_IR =
    (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CMAX =
    (TIMEOUT_CYCLES > CMAX_IR) ? TIMEOUT_CYCLES : CMAX_IR;
  localparam int CW = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t INH_LAST = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t RTS_LAST = cnt_t'(RTS_CYCLES - 1);
  localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bit_q, bit_d;
  logic            dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [1:0]            csync_q;
  logic [1:0]            dsync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  lvl_q, lvl_d;
  logic                  fall;
  logic                  dat_s;
  logic                  abort;

  // Two-flop synchronisers ahead of the clock glitch filter.
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      csync_q <= '0;
      dsync_q <= '0;
      filt_q  <= '0;
      lvl_q   <= 1'b0;
    end else begin
      csync_q <= {csync_q[0], ps2c_in};
      dsync_q <= {dsync_q[0], ps2d_in};
      filt_q  <= {filt_q[FILTER_LEN-2:0], csync_q[1]};
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    if (&filt_q)
      lvl_d = 1'b1;
    else if (~|filt_q)
      lvl_d = 1'b0;
  end

  assign fall  = lvl_q & ~lvl_d;
  assign dat_s = dsync_q[1];

  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (WR) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
          frame_d = {1'b1, ~^DIN, DIN};
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = S_RTS;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_RTS: begin
        if (cnt_q == RTS_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_DATA: begin
        if (fall) begin
          dout_d  = ~frame_q[0];
          frame_d = {1'b0, frame_q[9:1]};
          bit_d   = bit_q + 4'd1;
          cnt_d   = '0;
          if (bit_q == 4'd9)
            state_d = S_ACK;
        end else if (cnt_q >= TMO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_ACK: begin
        dout_d = 1'b0;
        if (fall) begin
          cnt_d = '0;
          if (dat_s) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q >= TMO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_WAIT: begin
        if (lvl_q && dat_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q >= TMO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b0;
      end
    endcase

    // Device went silent: free the bus and report.
    if (abort) begin
      state_d = S_IDLE;
      dout_d  = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end
  end

  assign ps2c_oe = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2d_oe = dout_q;
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on open-drain lines, frame
// reference built from the byte's one-count, pulse and timing checks.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RTSC = 10;
  localparam int TMO  = 5000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       busy, done, err;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_done = 0;

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTSC),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(8)
  ) dut (
    .Reloj(clk),
    .RST(rst),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .WR(wr),
    .DIN(din),
    .BUSY(busy),
    .DONE(done),
    .ERR(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
    if (done && busy) busy_done <= busy_done + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones;
    logic par;
    ones = $countones(d);
    par = (ones % 2 == 0);
    return {1'b1, par, d};
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 wr = 1'b1;
    din = b;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic measure_req(output int inh, output int rts);
    inh = 0;
    rts = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!ps2c_oe) break;
      if (ps2d_oe) rts++;
      else inh++;
    end
  endtask

  task automatic dev_xfer(input bit ack, input int abort_edge,
                          output logic [9:0] got, output bit ok);
    int w;
    ok = 1'b0;
    got = '0;
    w = 0;
    while (!(ps2c_in && !ps2d_in) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w < 3000) begin
      ok = 1'b1;
      repeat (50) @(negedge clk);
      for (int e = 1; e <= 11; e++) begin
        dev_clk = 1'b0;
        if (e == abort_edge) break;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (e <= 10) got[e-1] = ps2d_in;
        if (e == 10 && ack) dev_dat = 1'b0;
        if (e == 11) begin
          repeat (20) @(negedge clk);
          dev_dat = 1'b1;
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
  endtask

  task automatic do_xfer(input logic [7:0] b, input bit ack,
                         output int inh, output int rts,
                         output logic [9:0] got, output bit ok,
                         output int dd, output int de);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    measure_req(inh, rts);
    dev_xfer(ack, 0, got, ok);
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    if (busy) ok = 1'b0;
    repeat (3) @(negedge clk);
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++;
    if ({ps2c_oe, ps2d_oe, busy, done, err} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_outputs: got %b exp 00000",
               {ps2c_oe, ps2d_oe, busy, done, err});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    int inh, rts, dd, de;
    logic [9:0] got, exp;
    bit ok;
    exp = exp_frame(8'hED);
    send(8'hED);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL busy_after_wr: got %b exp 1", busy);
    end
    measure_req(inh, rts);
    nvec++;
    if (inh != INH) begin
      nerr++;
      $display("FAIL inhibit_len: got %0d exp %0d", inh, INH);
    end
    nvec++;
    if (rts != RTSC) begin
      nerr++;
      $display("FAIL rts_len: got %0d exp %0d", rts, RTSC);
    end
    dev_xfer(1'b1, 0, got, ok);
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    nvec++;
    if (!ok || got !== exp || got !== 10'b11_1110_1101) begin
      nerr++;
      $display("FAIL frame_ED: got %b exp %b ok=%0d", got, exp, ok);
    end
    nvec++;
    if (busy !== 1'b0 || done_cnt != 1 || err_cnt != 0) begin
      nerr++;
      $display("FAIL done_ED: busy=%b done=%0d err=%0d exp 0/1/0",
               busy, done_cnt, err_cnt);
    end
    dd = 0;
    de = 0;
  endtask

  task automatic test_parity;
    int inh, rts, dd, de;
    logic [9:0] got;
    bit ok;
    logic [7:0] v [2];
    logic pe [2];
    v[0] = 8'h01; pe[0] = 1'b0;
    v[1] = 8'hFF; pe[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_xfer(v[k], 1'b1, inh, rts, got, ok, dd, de);
      nvec++;
      if (!ok || got[8] !== pe[k] || got !== exp_frame(v[k])) begin
        nerr++;
        $display("FAIL parity_%h: got %b exp par %b", v[k], got, pe[k]);
      end
      nvec++;
      if (dd != 1 || de != 0) begin
        nerr++;
        $display("FAIL pulse_%h: done=%0d err=%0d exp 1/0", v[k], dd, de);
      end
    end
  endtask

  task automatic test_timeout;
    int inh, rts, c, d0;
    d0 = done_cnt;
    send(8'h5A);
    measure_req(inh, rts);
    c = 0;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      c++;
      if (err) break;
    end
    nvec++;
    if (err !== 1'b1 || c != TMO) begin
      nerr++;
      $display("FAIL timeout_len: got %0d err=%b exp %0d", c, err, TMO);
    end
    nvec++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000 || done_cnt != d0) begin
      nerr++;
      $display("FAIL timeout_state: got %b done=%0d exp 000 done=%0d",
               {ps2c_oe, ps2d_oe, busy}, done_cnt, d0);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_noack;
    int inh, rts, dd, de;
    logic [9:0] got;
    bit ok;
    do_xfer(8'h12, 1'b0, inh, rts, got, ok, dd, de);
    nvec++;
    if (!ok || dd != 0 || de != 1) begin
      nerr++;
      $display("FAIL noack: done=%0d err=%0d ok=%0d exp 0/1", dd, de, ok);
    end
  endtask

  task automatic test_busy_ignore;
    int inh, rts, d0;
    logic [9:0] got;
    bit ok, bsy;
    d0 = done_cnt;
    send(8'hED);
    measure_req(inh, rts);
    bsy = 1'b0;
    fork
      dev_xfer(1'b1, 0, got, ok);
      begin
        repeat (600) @(negedge clk);
        @(posedge clk);
        #1 wr = 1'b1;
        din = 8'hAA;
        @(posedge clk);
        #1 wr = 1'b0;
        @(negedge clk);
        bsy = busy;
      end
    join
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    nvec++;
    if (!ok || got !== exp_frame(8'hED) || bsy !== 1'b1) begin
      nerr++;
      $display("FAIL wr_ignored: got %b exp %b busy=%b",
               got, exp_frame(8'hED), bsy);
    end
    nvec++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL wr_ignored_done: got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int inh, rts, dd, de;
    logic [9:0] got, e;
    bit ok;
    e = exp_frame(8'hED);
    send(8'hED);
    measure_req(inh, rts);
    dev_xfer(1'b1, 5, got, ok);
    repeat (20) @(negedge clk);
    nvec++;
    if (ps2d_oe !== ~e[4] || busy !== 1'b1) begin
      nerr++;
      $display("FAIL edge5_data: got oe=%b busy=%b exp %b/1",
               ps2d_oe, busy, ~e[4]);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_mid: got %b exp 000", {ps2c_oe, ps2d_oe, busy});
    end
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    do_xfer(8'hF4, 1'b1, inh, rts, got, ok, dd, de);
    nvec++;
    if (!ok || got !== exp_frame(8'hF4) || dd != 1 || de != 0) begin
      nerr++;
      $display("FAIL after_reset_F4: got %b exp %b done=%0d err=%0d",
               got, exp_frame(8'hF4), dd, de);
    end
  endtask

  task automatic test_random;
    int inh, rts, dd, de;
    logic [9:0] got;
    logic [7:0] b;
    bit ok;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom_range(0, 255));
      do_xfer(b, 1'b1, inh, rts, got, ok, dd, de);
      nvec++;
      if (!ok || got !== exp_frame(b) || dd != 1 || de != 0) begin
        nerr++;
        $display("FAIL rand_%h: got %b exp %b done=%0d err=%0d",
                 b, got, exp_frame(b), dd, de);
      end
    end
  endtask

  task automatic test_pulses;
    nvec++;
    if (both_cnt != 0 || busy_done != 0) begin
      nerr++;
      $display("FAIL pulse_rules: overlap=%0d busy_at_done=%0d exp 0/0",
               both_cnt, busy_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_timeout();
    test_noack();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_pulses();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
